// File: rtl/mult_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Optional build macro: MULT_EARLY_TERM_EN (used by the files importing this package).
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int N_REQ = 2;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/mult_shift_add_step.sv
// Shift-and-add datapath: accumulator, multiplier shifter and running product.
// MULT_EARLY_TERM_EN adds a flag telling the controller the current step is the last useful one.
module mult_shift_add_step
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_i,
   input  logic                       step_i,
   input  logic [WIDTH-1:0]           a_i,
   input  logic [WIDTH-1:0]           b_i,
   output logic [prod_w(WIDTH)-1:0]   product_o
`ifdef MULT_EARLY_TERM_EN
   ,
   output logic                       last_step_o
`endif
);

   localparam int PW = prod_w(WIDTH);

   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    product_q, product_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;

   always_comb begin
      acc_d     = acc_q;
      mplier_d  = mplier_q;
      product_d = product_q;
      if (load_i) begin
         acc_d     = PW'(a_i);
         mplier_d  = b_i;
         product_d = '0;
      end else if (step_i) begin
         if (mplier_q[0]) begin
            product_d = product_q + acc_q;
         end
         acc_d    = acc_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q     <= '0;
         mplier_q  <= '0;
         product_q <= '0;
      end else begin
         acc_q     <= acc_d;
         mplier_q  <= mplier_d;
         product_q <= product_d;
      end
   end

   assign product_o = product_q;

`ifdef MULT_EARLY_TERM_EN
   // Nothing left to add once the remaining multiplier bits are all zero.
   assign last_step_o = ((mplier_q >> 1) == '0);
`endif

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one iterative multiplier between two requesters.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mult_rr_scheduler
   import mult_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [WIDTH-1:0]         req_a0,
   input  logic [WIDTH-1:0]         req_b0,
   input  logic [WIDTH-1:0]         req_a1,
   input  logic [WIDTH-1:0]         req_b1,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_id,
   output logic [2*WIDTH-1:0]       rsp_product,
   output logic                     busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rr_last_q, rr_last_d;
   logic             owner_q, owner_d;
   logic             grant_idx;
   logic             handshake;
   logic             step;
   logic [WIDTH-1:0] sel_a, sel_b;
`ifdef MULT_EARLY_TERM_EN
   logic             last_step;
`endif

   // On contention the requester that did not win last time is granted.
   assign grant_idx = (&req_valid) ? ~rr_last_q : req_valid[1];
   assign handshake = (state_q == IDLE) && (|req_valid) && !rst;
   assign req_ready = handshake ? (N_REQ'(1) << grant_idx) : '0;
   assign sel_a     = grant_idx ? req_a1 : req_a0;
   assign sel_b     = grant_idx ? req_b1 : req_b0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_last_d = rr_last_q;
      owner_d   = owner_q;
      step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               cnt_d     = '0;
               owner_d   = grant_idx;
               rr_last_d = grant_idx;
               state_d   = CALC;
`ifdef MULT_EARLY_TERM_EN
               if (sel_b == '0) state_d = DONE;
`endif
            end
         end
         CALC: begin
            step  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
`ifdef MULT_EARLY_TERM_EN
            if (last_step) state_d = DONE;
`endif
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rr_last_q <= 1'b1;
         owner_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_last_q <= rr_last_d;
         owner_q   <= owner_d;
      end
   end

   mult_shift_add_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .clk         (clk),
      .rst         (rst),
      .load_i      (handshake),
      .step_i      (step),
      .a_i         (sel_a),
      .b_i         (sel_b),
      .product_o   (rsp_product)
`ifdef MULT_EARLY_TERM_EN
      ,
      .last_step_o (last_step)
`endif
   );

   assign rsp_valid = (state_q == DONE);
   assign rsp_id    = owner_q;
   assign busy      = (state_q != IDLE);

endmodule
